// File: rtl/dm_handshake_if.sv
// dm_handshake_if: request/response handshake bundle between a memory client and dm_handshake.
interface dm_handshake_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_ext;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    modport master (
        output req_valid, req_we, req_addr, req_size, req_ext, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_ext, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_handshake.sv
// dm_handshake: single-outstanding byte/half/word data memory with fixed-latency valid/ready response.
module dm_handshake #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 12,
    parameter int LATENCY     = 1
) (
    input logic           clk,
    input logic           rst,
    dm_handshake_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, ext_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [31:0]           wdata_q, rdata_q;
    logic [31:0]           mem_q [DEPTH_WORDS] = '{default: '0};

    // With LATENCY=1 the commit edge is the accept edge, so fields come straight from the bus.
    logic                  idle, commit, c_we, c_ext, c_err;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [1:0]            c_size;
    logic [31:0]           c_wdata, rword, rsh, ld, mask, wsh;
    logic [4:0]            sh;

    assign idle    = state_q == IDLE;
    assign c_we    = idle ? bus.req_we    : we_q;
    assign c_ext   = idle ? bus.req_ext   : ext_q;
    assign c_addr  = idle ? bus.req_addr  : addr_q;
    assign c_size  = idle ? bus.req_size  : size_q;
    assign c_wdata = idle ? bus.req_wdata : wdata_q;
    assign c_err   = c_size == 2'd3 || (c_size == 2'd1 && c_addr[0]) || (c_size == 2'd2 && c_addr[1:0] != 2'd0);
    assign commit  = state_d == RESP && state_q != RESP;
    assign sh      = {c_addr[1:0], 3'b000};
    assign rword   = mem_q[c_addr[ADDR_WIDTH-1:2]];
    assign rsh     = rword >> sh;
    assign ld      = c_size == 2'd0 ? {{24{c_ext & rsh[7]}}, rsh[7:0]} :
                     c_size == 2'd1 ? {{16{c_ext & rsh[15]}}, rsh[15:0]} : rword;
    assign mask    = c_size == 2'd0 ? 32'hFF << sh : c_size == 2'd1 ? 32'hFFFF << sh : '1;
    assign wsh     = c_wdata << sh;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (idle && bus.req_valid) begin
            state_d = LATENCY > 1 ? WAIT : RESP;
            cnt_d   = 4'(LATENCY - 1);
        end else if (state_q == WAIT) begin
            state_d = cnt_q == 4'd1 ? RESP : WAIT;
            cnt_d   = cnt_q - 4'd1;
        end else if (state_q == RESP && bus.resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (idle && bus.req_valid) begin
                we_q    <= bus.req_we;
                ext_q   <= bus.req_ext;
                addr_q  <= bus.req_addr;
                size_q  <= bus.req_size;
                wdata_q <= bus.req_wdata;
            end
            if (commit) begin
                err_q   <= c_err;
                rdata_q <= (c_we || c_err) ? '0 : ld;
            end
        end
    end

    // Memory is deliberately outside the reset domain; an aborted store never reaches commit.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_we && !c_err)
            mem_q[c_addr[ADDR_WIDTH-1:2]] <= (rword & ~mask) | (wsh & mask);
    end

    assign bus.req_ready  = idle;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dm_handshake.sv
// tb_dm_handshake: randomized and directed checks of dm_handshake (LATENCY 1 and 4) against a byte-level memory model.
module tb_dm_handshake;
    logic clk = 0, rst = 1, sel = 0;
    logic v_valid = 0, v_we = 0, v_ext = 0, v_rready = 0;
    logic [11:0] v_addr = 0;
    logic [1:0]  v_size = 0;
    logic [31:0] v_wdata = 0;
    logic [31:0] mdl [2][1024];
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    dm_handshake_if #(.ADDR_WIDTH(12)) b1();
    dm_handshake_if #(.ADDR_WIDTH(12)) b4();

    assign b1.req_valid  = v_valid & ~sel;
    assign b4.req_valid  = v_valid & sel;
    assign b1.req_we     = v_we;
    assign b4.req_we     = v_we;
    assign b1.req_ext    = v_ext;
    assign b4.req_ext    = v_ext;
    assign b1.req_addr   = v_addr;
    assign b4.req_addr   = v_addr;
    assign b1.req_size   = v_size;
    assign b4.req_size   = v_size;
    assign b1.req_wdata  = v_wdata;
    assign b4.req_wdata  = v_wdata;
    assign b1.resp_ready = v_rready;
    assign b4.resp_ready = v_rready;

    wire        o_ready  = sel ? b4.req_ready  : b1.req_ready;
    wire        o_rvalid = sel ? b4.resp_valid : b1.resp_valid;
    wire        o_err    = sel ? b4.resp_err   : b1.resp_err;
    wire [31:0] o_rdata  = sel ? b4.resp_rdata : b1.resp_rdata;

    dm_handshake #(.LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    dm_handshake #(.LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(logic [31:0] w, int off, int nb, bit ext);
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
        if (ext && nb < 4 && v[8*nb-1])
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(logic [31:0] w, int off, int nb, logic [31:0] wd);
        for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    task automatic xact(input bit we, input logic [11:0] a, input logic [1:0] sz, input bit ext,
                        input logic [31:0] wd, input int hold, output logic [31:0] rd, output bit e);
        logic [31:0] exp;
        int nb, lat, off;
        nb  = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        off = int'(a[1:0]);
        e   = sz == 2'd3 || (off % nb) != 0;
        exp = (we || e) ? 32'h0 : ref_load(mdl[sel][a[11:2]], off, nb, ext);
        if (we && !e) mdl[sel][a[11:2]] = ref_store(mdl[sel][a[11:2]], off, nb, wd);
        @(negedge clk);
        chk("ready_idle", {31'b0, o_ready}, 1);
        v_valid = 1; v_we = we; v_addr = a; v_size = sz; v_ext = ext; v_wdata = wd; v_rready = 0;
        @(posedge clk);
        @(negedge clk);
        v_valid = 1'($urandom); v_we = 1'($urandom); v_addr = 12'($urandom);
        v_size = 2'($urandom); v_ext = 1'($urandom); v_wdata = $urandom;
        lat = 1;
        while (!o_rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, sel ? 4 : 1);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", {31'b0, o_rvalid}, 1);
            chk("hold_ready", {31'b0, o_ready}, 0);
            chk("hold_data", o_rdata, exp);
            @(negedge clk);
        end
        v_rready = 1;
        chk("resp_valid", {31'b0, o_rvalid}, 1);
        chk("resp_ready_low", {31'b0, o_ready}, 0);
        chk("resp_rdata", o_rdata, exp);
        chk("resp_err", {31'b0, o_err}, {31'b0, e});
        rd = o_rdata;
        @(negedge clk);
        v_rready = 0; v_valid = 0;
        chk("ready_after", {31'b0, o_ready}, 1);
        chk("valid_after", {31'b0, o_rvalid}, 0);
    endtask

    initial begin
        logic [31:0] rd;
        bit e;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++) mdl[d][i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_ready1", {31'b0, b1.req_ready}, 1);
        chk("rst_valid1", {31'b0, b1.resp_valid}, 0);
        chk("rst_rdata4", b4.resp_rdata, 0);
        chk("rst_err4", {31'b0, b4.resp_err}, 0);

        sel = 0;
        xact(1, 12'h010, 2, 0, 32'hDEADBEEF, 0, rd, e);
        xact(0, 12'h010, 2, 0, 0, 0, rd, e);
        chk("d_word", rd, 32'hDEADBEEF);
        xact(1, 12'h013, 0, 0, 32'h00000080, 0, rd, e);
        xact(0, 12'h013, 0, 1, 0, 1, rd, e);
        chk("d_byte_sext", rd, 32'hFFFFFF80);
        xact(0, 12'h013, 0, 0, 0, 0, rd, e);
        chk("d_byte_zext", rd, 32'h00000080);
        xact(0, 12'h010, 2, 0, 0, 0, rd, e);
        chk("d_word_merged", rd, 32'h80ADBEEF);
        xact(1, 12'h022, 1, 0, 32'h00008001, 0, rd, e);
        xact(0, 12'h022, 1, 1, 0, 0, rd, e);
        chk("d_half_sext", rd, 32'hFFFF8001);
        xact(0, 12'h020, 2, 0, 0, 0, rd, e);
        chk("d_half_word", rd, 32'h80010000);
        xact(1, 12'h011, 2, 0, 32'h12345678, 0, rd, e);
        chk("d_err_store", {31'b0, e}, 1);
        xact(0, 12'h023, 1, 0, 0, 0, rd, e);
        chk("d_err_load", {31'b0, e}, 1);
        xact(0, 12'h010, 2, 0, 0, 0, rd, e);
        chk("d_unchanged", rd, 32'h80ADBEEF);

        sel = 1;
        xact(1, 12'h040, 2, 0, 32'hCAFEF00D, 3, rd, e);
        xact(0, 12'h040, 2, 0, 0, 3, rd, e);
        chk("l4_word", rd, 32'hCAFEF00D);
        @(negedge clk);
        v_valid = 1; v_we = 1; v_addr = 12'h040; v_size = 2; v_ext = 0; v_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        v_valid = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("abort_ready", {31'b0, o_ready}, 1);
        chk("abort_valid", {31'b0, o_rvalid}, 0);
        chk("abort_rdata", o_rdata, 0);
        chk("abort_err", {31'b0, o_err}, 0);
        xact(0, 12'h040, 2, 0, 0, 0, rd, e);
        chk("abort_old", rd, 32'hCAFEF00D);

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            repeat (80)
                xact(1'($urandom), 12'($urandom_range(0, 63)), 2'($urandom), 1'($urandom),
                     $urandom, int'($urandom_range(0, 3)), rd, e);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dm_handshake.md
DM_HANDSHAKE -- requirements
Module: dm_handshake

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit memory words (power of 2, >= 4).
REQ-002 Parameter ADDR_WIDTH, default 12, byte-address width; SHALL equal log2(DEPTH_WORDS)+2.
REQ-003 Parameter LATENCY, default 1, cycles from request acceptance to response valid (legal 1..8).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_WIDTH  byte address; [ADDR_WIDTH-1:2] word index, [1:0] byte offset.
REQ-010 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-011 req_ext  input  1  load extension: 1 sign, 0 zero; ignored for word and store.
REQ-012 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  consumer accepts response.
REQ-015 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-016 resp_err  output  1  misaligned or reserved-size request.

Function
REQ-017 Request accepted on a clock edge where req_valid && req_ready; only one request outstanding.
REQ-018 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-019 IDLE + accept: capture all req_* fields; go to WAIT if LATENCY > 1, else RESP; load counter with LATENCY-1.
REQ-020 WAIT: decrement counter each cycle; go to RESP the cycle counter reaches 1.
REQ-021 RESP: resp_valid = 1; resp_rdata/resp_err stable until resp_valid && resp_ready, then go to IDLE.
REQ-022 Next request accepted no earlier than the cycle after the response handshake (no same-cycle turnaround).
REQ-023 Little-endian lanes: offset 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24]; halfword addr[1]=0 -> [15:0], 1 -> [31:16].
REQ-024 Error if size 11, halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-025 Error request: no memory write, resp_err = 1, resp_rdata = 0.
REQ-026 Store: memory written exactly once, on the edge entering RESP; only addressed byte lanes change.
REQ-027 Load: memory word read on the edge entering RESP; selected lane zero/sign-extended per captured req_ext to 32 bits.
REQ-028 Load after store to same word returns post-store contents (no stale data).
REQ-029 Input changes while not in IDLE have no effect.

Reset
REQ-030 rst dominates all other inputs on the same edge: state -> IDLE, counter -> 0.
REQ-031 After reset: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-032 rst mid-operation (WAIT or RESP) aborts the request; a store not yet committed SHALL not write memory.
REQ-033 rst does not clear memory; memory SHALL initialise to all-zero at simulation start.

Verification
REQ-034 LATENCY=1: store word 0xDEADBEEF at 0x010, load word 0x010 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid 1 cycle after accept.
REQ-035 Store byte 0x80 at 0x013 over that word, load byte 0x013 ext=1 -> 0xFFFFFF80, ext=0 -> 0x00000080; load word -> 0x80ADBEEF.
REQ-036 Store half 0x8001 at 0x022, load half 0x022 ext=1 -> 0xFFFF8001; load word 0x020 -> 0x80010000.
REQ-037 Word store at 0x011 and half load at 0x023 -> resp_err 1, rdata 0, word 0x010 unchanged.
REQ-038 LATENCY=4, resp_ready held 0 for 3 cycles -> resp_valid at accept+4, data stable, req_ready 0 until cycle after handshake.
REQ-039 rst asserted in WAIT of a store -> IDLE next cycle, outputs at reset values, subsequent load returns old data.
